branch_predictor_table: RTL and testbench



---
 rtl/branch_predictor_table.sv | 236 +++++++++++++++++++++++
 tb/tb_branch_predictor_table.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_table.sv
// ============================================================================
// branch_predictor_table
// ----------------------------------------------------------------------------
// Purpose:
//   Gshare-style direction predictor that sits beside the fetch stage. It is a
//   table of 2**INDEX_BITS saturating counters. The table is indexed by the
//   low bits of the branch PC, XORed with a global history register (ghr). The
//   ghr is zero-extended into the low index bits. Setting HIST_BITS=0 removes
//   the ghr and turns the table into a plain bimodal predictor.
//
//   The block answers one prediction request and accepts one resolved-branch
//   update in the same cycle. Predictions are registered and appear one cycle
//   after the request.
//
//   A request and an update in the same cycle use read-before-write. The
//   request sees the counters and ghr as they were before that edge. The
//   update takes effect for requests sampled on the next edge onward.
//
//   The ghr is non-speculative. It shifts in the actual outcome on every
//   update and never changes on a request.
//
//   A 16-bit saturating counter records mispredicted updates for performance
//   monitoring. An update is a mispredict when the MSB of the counter, before
//   the update, differs from the resolved outcome.
//
// Parameters:
//   PC_BITS    width of req_pc (must be >= INDEX_BITS)
//   INDEX_BITS log2 of the number of counters
//   CTR_BITS   counter width (>= 1); prediction is the counter MSB
//   HIST_BITS  global history length (0 .. INDEX_BITS); 0 disables history
//   CTR_INIT   reset value of every counter (< 2**CTR_BITS)
//
// Ports:
//   clk         in   clock; all state changes on the rising edge
//   rst         in   synchronous active-high reset; overrides any request or
//                    update presented in the same cycle
//   req_valid   in   prediction request this cycle
//   req_pc      in   branch PC of the request
//   pred_valid  out  registered; high one cycle after req_valid
//   pred_taken  out  registered predicted direction; holds when idle
//   pred_index  out  registered table index used; holds when idle
//   upd_valid   in   resolved-branch update this cycle
//   upd_index   in   index previously returned on pred_index
//   upd_taken   in   actual branch outcome
//   miss_count  out  saturating count of mispredicted updates
// ============================================================================
module branch_predictor_table #(
  parameter int PC_BITS    = 8,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 4,
  parameter int CTR_INIT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [PC_BITS-1:0]    req_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  output logic [15:0]           miss_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
  localparam logic [CTR_BITS-1:0] CTR_ZERO  = '0;
  localparam logic [CTR_BITS-1:0] CTR_ONE   = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_RESET = CTR_BITS'(CTR_INIT);

  localparam logic [15:0] MISS_MAX = 16'hFFFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_d [ENTRIES];

  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
  logic [15:0]           miss_q,       miss_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] hist_idx;   // ghr zero-extended to index width
  logic [INDEX_BITS-1:0] req_idx;
  logic [CTR_BITS-1:0]   req_ctr;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic [CTR_BITS-1:0]   upd_next;
  logic                  mispredict;

  // Only the low INDEX_BITS of the PC take part in indexing. The remaining
  // upper bits are reduced into a deliberately unused net.
  if (PC_BITS > INDEX_BITS) begin : g_pc_hi
    logic unused_pc_hi;
    assign unused_pc_hi = ^req_pc[PC_BITS-1:INDEX_BITS];
  end

  // --------------------------------------------------------------------------
  // Global history register.
  // The ghr exists only when HIST_BITS > 0. It shifts left on every update
  // with the resolved outcome entering at the LSB. Requests never modify it,
  // so a request always uses the history as it stood before the edge.
  // --------------------------------------------------------------------------
  if (HIST_BITS == 0) begin : g_no_hist

    assign hist_idx = '0;

  end else begin : g_hist

    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    // Next-history computation. A single-bit history simply takes the outcome.
    if (HIST_BITS == 1) begin : g_shift1
      always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
          ghr_d = upd_taken;
        end
      end
    end else begin : g_shiftn
      always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
          ghr_d = {ghr_q[HIST_BITS-2:0], upd_taken};
        end
      end
    end

    // History register with synchronous clear.
    always_ff @(posedge clk) begin
      if (rst) begin
        ghr_q <= '0;
      end else begin
        ghr_q <= ghr_d;
      end
    end

    assign hist_idx = INDEX_BITS'(ghr_q);

  end

  // --------------------------------------------------------------------------
  // Request path.
  // The table is read with the current (pre-edge) contents, which gives
  // read-before-write against a same-cycle update to the same entry. When no
  // request is present, the direction and index keep their previous values.
  // --------------------------------------------------------------------------
  always_comb begin
    req_idx      = req_pc[INDEX_BITS-1:0] ^ hist_idx;
    req_ctr      = ctr_q[req_idx];
    pred_valid_d = req_valid;
    pred_taken_d = pred_taken_q;
    pred_index_d = pred_index_q;
    if (req_valid) begin
      pred_taken_d = req_ctr[CTR_BITS-1];
      pred_index_d = req_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Update path.
  // The addressed counter moves one step toward the outcome and saturates at
  // both ends. The mispredict decision uses the counter value before this
  // update.
  // --------------------------------------------------------------------------
  always_comb begin
    upd_ctr  = ctr_q[upd_index];
    upd_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) begin
        upd_next = upd_ctr + CTR_ONE;
      end
    end else begin
      if (upd_ctr != CTR_ZERO) begin
        upd_next = upd_ctr - CTR_ONE;
      end
    end
    mispredict = upd_valid && (upd_ctr[CTR_BITS-1] != upd_taken);
  end

  // Next-state table: only the entry named by upd_index can change.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ctr_d[i] = ctr_q[i];
      if (upd_valid && (upd_index == INDEX_BITS'(i))) begin
        ctr_d[i] = upd_next;
      end
    end
  end

  // Saturating mispredict counter: it sticks at all-ones.
  always_comb begin
    miss_d = miss_q;
    if (mispredict && (miss_q != MISS_MAX)) begin
      miss_d = miss_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers.
  // Reset has priority over everything. Any request or update presented with
  // rst is dropped. This includes a prediction that would otherwise appear on
  // the following cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_index_q <= '0;
      miss_q       <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_index_q <= pred_index_d;
      miss_q       <= miss_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_index = pred_index_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// ============================================================================
// tb_branch_predictor_table
// ----------------------------------------------------------------------------
// Directed bench for branch_predictor_table. It drives two instances from a
// shared clock and reset:
//   dut_a : default parameters (gshare, 4-bit history)
//   dut_b : HIST_BITS=0 (plain bimodal table)
// Each scenario task drives its stimulus and compares the outputs against
// hand-computed values. Outputs are sampled 1 ns after the rising edge.
// ============================================================================
module tb_branch_predictor_table;

  logic        clk;
  logic        rst;

  logic        a_req_valid, a_pred_valid, a_pred_taken, a_upd_valid, a_upd_taken;
  logic [7:0]  a_req_pc;
  logic [3:0]  a_pred_index, a_upd_index;
  logic [15:0] a_miss_count;

  logic        b_req_valid, b_pred_valid, b_pred_taken, b_upd_valid, b_upd_taken;
  logic [7:0]  b_req_pc;
  logic [3:0]  b_pred_index, b_upd_index;
  logic [15:0] b_miss_count;

  int errors = 0;
  int checks = 0;

  branch_predictor_table dut_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (a_req_valid),
    .req_pc     (a_req_pc),
    .pred_valid (a_pred_valid),
    .pred_taken (a_pred_taken),
    .pred_index (a_pred_index),
    .upd_valid  (a_upd_valid),
    .upd_index  (a_upd_index),
    .upd_taken  (a_upd_taken),
    .miss_count (a_miss_count)
  );

  branch_predictor_table #(.HIST_BITS(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (b_req_valid),
    .req_pc     (b_req_pc),
    .pred_valid (b_pred_valid),
    .pred_taken (b_pred_taken),
    .pred_index (b_pred_index),
    .upd_valid  (b_upd_valid),
    .upd_index  (b_upd_index),
    .upd_taken  (b_upd_taken),
    .miss_count (b_miss_count)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the full sequence needs well under this much time.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic upd_a(input logic [3:0] idx, input logic taken);
    a_upd_valid = 1'b1; a_upd_index = idx; a_upd_taken = taken;
    tick();
    a_upd_valid = 1'b0;
  endtask

  task automatic req_a(input logic [7:0] pc);
    a_req_valid = 1'b1; a_req_pc = pc;
    tick();
    a_req_valid = 1'b0;
  endtask

  task automatic upd_b(input logic [3:0] idx, input logic taken);
    b_upd_valid = 1'b1; b_upd_index = idx; b_upd_taken = taken;
    tick();
    b_upd_valid = 1'b0;
  endtask

  task automatic req_b(input logic [7:0] pc);
    b_req_valid = 1'b1; b_req_pc = pc;
    tick();
    b_req_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    // Requests and updates presented during reset must be ignored.
    rst = 1'b1;
    a_req_valid = 1'b1; a_req_pc = 8'h0F;
    a_upd_valid = 1'b1; a_upd_index = 4'hF; a_upd_taken = 1'b1;
    tick();
    rst = 1'b0; a_req_valid = 1'b0; a_upd_valid = 1'b0;
    checks++; if (a_pred_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred_valid: got %0b expected 0", a_pred_valid); end
    checks++; if (a_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred_taken: got %0b expected 0", a_pred_taken); end
    checks++; if (a_pred_index !== 4'h0) begin errors++; $display("[TB] FAIL reset_pred_index: got %0h expected 0", a_pred_index); end
    checks++; if (a_miss_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_miss_a: got %0h expected 0", a_miss_count); end
    checks++; if (b_miss_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_miss_b: got %0h expected 0", b_miss_count); end
    req_a(8'h05);
    checks++; if (a_pred_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_valid: got %0b expected 1", a_pred_valid); end
    checks++; if (a_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_taken: got %0b expected 1", a_pred_taken); end
    checks++; if (a_pred_index !== 4'h5) begin errors++; $display("[TB] FAIL reset_req_index: got %0h expected 5", a_pred_index); end
    // Idle cycle: valid drops while direction and index hold.
    tick();
    checks++; if (a_pred_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_valid: got %0b expected 0", a_pred_valid); end
    checks++; if (a_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL idle_taken_hold: got %0b expected 1", a_pred_taken); end
    checks++; if (a_pred_index !== 4'h5) begin errors++; $display("[TB] FAIL idle_index_hold: got %0h expected 5", a_pred_index); end
    checks++; if (a_miss_count !== 16'h0) begin errors++; $display("[TB] FAIL idle_miss: got %0h expected 0", a_miss_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_saturation();
    // Bimodal instance, entry 3 starts at 2.
    do_reset();
    upd_b(4'h3, 1'b1); upd_b(4'h3, 1'b1); upd_b(4'h3, 1'b1);      // 3,3,3
    req_b(8'h03);
    checks++; if (b_pred_index !== 4'h3) begin errors++; $display("[TB] FAIL sat_index: got %0h expected 3", b_pred_index); end
    checks++; if (b_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL sat_top_taken: got %0b expected 1", b_pred_taken); end
    upd_b(4'h3, 1'b0); upd_b(4'h3, 1'b0);                         // 2,1
    req_b(8'h03);
    checks++; if (b_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL sat_mid_taken: got %0b expected 0", b_pred_taken); end
    upd_b(4'h3, 1'b0); upd_b(4'h3, 1'b0); upd_b(4'h3, 1'b0);      // 0,0,0
    req_b(8'h03);
    checks++; if (b_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL sat_bottom_taken: got %0b expected 0", b_pred_taken); end
    upd_b(4'h3, 1'b1);                                            // 1
    req_b(8'h03);
    checks++; if (b_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL sat_hysteresis: got %0b expected 0", b_pred_taken); end
    upd_b(4'h3, 1'b1);                                            // 2
    req_b(8'h03);
    checks++; if (b_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL sat_recover: got %0b expected 1", b_pred_taken); end
    // Misses: N@3, N@2, T@0, T@1.
    checks++; if (b_miss_count !== 16'd4) begin errors++; $display("[TB] FAIL sat_miss: got %0d expected 4", b_miss_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_collision();
    do_reset();
    // Gshare: taken update at entry 8 makes ghr=0001; entry 3 stays at 2.
    upd_a(4'h8, 1'b1);
    a_req_valid = 1'b1; a_req_pc = 8'h02;
    a_upd_valid = 1'b1; a_upd_index = 4'h3; a_upd_taken = 1'b0;
    tick();
    a_req_valid = 1'b0; a_upd_valid = 1'b0;
    checks++; if (a_pred_valid !== 1'b1) begin errors++; $display("[TB] FAIL coll_valid: got %0b expected 1", a_pred_valid); end
    checks++; if (a_pred_index !== 4'h3) begin errors++; $display("[TB] FAIL coll_index_old_ghr: got %0h expected 3", a_pred_index); end
    checks++; if (a_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL coll_taken_old_ctr: got %0b expected 1", a_pred_taken); end
    // Now ghr=0010 and entry 3 is 1.
    req_a(8'h01);
    checks++; if (a_pred_index !== 4'h3) begin errors++; $display("[TB] FAIL coll_next_index: got %0h expected 3", a_pred_index); end
    checks++; if (a_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL coll_next_taken: got %0b expected 0", a_pred_taken); end
    req_a(8'h03);
    checks++; if (a_pred_index !== 4'h1) begin errors++; $display("[TB] FAIL coll_pc3_index: got %0h expected 1", a_pred_index); end
    checks++; if (a_miss_count !== 16'd1) begin errors++; $display("[TB] FAIL coll_miss_a: got %0d expected 1", a_miss_count); end
    // Bimodal: request pc=3 with a not-taken update to entry 3 in one cycle.
    b_req_valid = 1'b1; b_req_pc = 8'h03;
    b_upd_valid = 1'b1; b_upd_index = 4'h3; b_upd_taken = 1'b0;
    tick();
    b_req_valid = 1'b0; b_upd_valid = 1'b0;
    checks++; if (b_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL collb_taken_old: got %0b expected 1", b_pred_taken); end
    req_b(8'h03);
    checks++; if (b_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL collb_taken_new: got %0b expected 0", b_pred_taken); end
    checks++; if (b_miss_count !== 16'd1) begin errors++; $display("[TB] FAIL collb_miss: got %0d expected 1", b_miss_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_history();
    do_reset();
    req_a(8'h00);
    checks++; if (a_pred_index !== 4'h0) begin errors++; $display("[TB] FAIL hist_initial_index: got %0h expected 0", a_pred_index); end
    // Entry 0: 2->3->2->3->3, ghr -> 1011.
    upd_a(4'h0, 1'b1); upd_a(4'h0, 1'b0); upd_a(4'h0, 1'b1); upd_a(4'h0, 1'b1);
    req_a(8'h00);
    checks++; if (a_pred_index !== 4'hB) begin errors++; $display("[TB] FAIL hist_pc00_index: got %0h expected b", a_pred_index); end
    req_a(8'h00);
    checks++; if (a_pred_index !== 4'hB) begin errors++; $display("[TB] FAIL hist_nonspec_index: got %0h expected b", a_pred_index); end
    req_a(8'h1B);
    checks++; if (a_pred_index !== 4'h0) begin errors++; $display("[TB] FAIL hist_pc1b_index: got %0h expected 0", a_pred_index); end
    checks++; if (a_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL hist_pc1b_taken: got %0b expected 1", a_pred_taken); end
    req_a(8'hF0);
    checks++; if (a_pred_index !== 4'hB) begin errors++; $display("[TB] FAIL hist_pcf0_index: got %0h expected b", a_pred_index); end
    req_a(8'h04);
    checks++; if (a_pred_index !== 4'hF) begin errors++; $display("[TB] FAIL hist_pc04_index: got %0h expected f", a_pred_index); end
    checks++; if (a_miss_count !== 16'd1) begin errors++; $display("[TB] FAIL hist_miss: got %0d expected 1", a_miss_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back();
    do_reset();
    // Entry 7 is 2. Each cycle carries a request and a not-taken update to it.
    a_req_valid = 1'b1; a_req_pc = 8'h07;
    a_upd_valid = 1'b1; a_upd_index = 4'h7; a_upd_taken = 1'b0;
    tick();
    checks++; if (a_pred_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid0: got %0b expected 1", a_pred_valid); end
    checks++; if (a_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL b2b_taken0: got %0b expected 1", a_pred_taken); end
    tick();
    checks++; if (a_pred_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid1: got %0b expected 1", a_pred_valid); end
    checks++; if (a_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL b2b_taken1: got %0b expected 0", a_pred_taken); end
    a_upd_valid = 1'b0;
    tick();
    a_req_valid = 1'b0;
    checks++; if (a_pred_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid2: got %0b expected 1", a_pred_valid); end
    checks++; if (a_pred_index !== 4'h7) begin errors++; $display("[TB] FAIL b2b_index2: got %0h expected 7", a_pred_index); end
    checks++; if (a_miss_count !== 16'd1) begin errors++; $display("[TB] FAIL b2b_miss: got %0d expected 1", a_miss_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_miss();
    logic t;
    do_reset();
    // Entry 0: 2->1 (miss), then 1->0 and 0->0 three times (no misses).
    upd_a(4'h0, 1'b0);
    checks++; if (a_miss_count !== 16'd1) begin errors++; $display("[TB] FAIL miss_first: got %0d expected 1", a_miss_count); end
    for (int i = 0; i < 4; i++) upd_a(4'h0, 1'b0);
    checks++; if (a_miss_count !== 16'd1) begin errors++; $display("[TB] FAIL miss_five: got %0d expected 1", a_miss_count); end
    // From counter 0: T,T, then alternating N,T. Every update mispredicts.
    for (int i = 0; i < 65533; i++) begin
      t = (i < 2) ? 1'b1 : ((i % 2) == 1);
      upd_a(4'h0, t);
    end
    checks++; if (a_miss_count !== 16'hFFFE) begin errors++; $display("[TB] FAIL miss_near_max: got %0h expected fffe", a_miss_count); end
    upd_a(4'h0, 1'b1);
    checks++; if (a_miss_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL miss_max: got %0h expected ffff", a_miss_count); end
    upd_a(4'h0, 1'b0);
    checks++; if (a_miss_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL miss_saturate: got %0h expected ffff", a_miss_count); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    // Entry 5 goes to 1 before reset. ghr and miss count are non-zero here.
    upd_a(4'h5, 1'b0);
    rst = 1'b1;
    a_req_valid = 1'b1; a_req_pc = 8'h05;
    a_upd_valid = 1'b1; a_upd_index = 4'h5; a_upd_taken = 1'b0;
    tick();
    rst = 1'b0; a_req_valid = 1'b0; a_upd_valid = 1'b0;
    checks++; if (a_pred_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid: got %0b expected 0", a_pred_valid); end
    checks++; if (a_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL mid_taken: got %0b expected 0", a_pred_taken); end
    checks++; if (a_pred_index !== 4'h0) begin errors++; $display("[TB] FAIL mid_index: got %0h expected 0", a_pred_index); end
    checks++; if (a_miss_count !== 16'h0) begin errors++; $display("[TB] FAIL mid_miss: got %0h expected 0", a_miss_count); end
    // With ghr=0 the index equals the PC, and every counter reads as CTR_INIT.
    for (int p = 0; p < 16; p++) begin
      req_a(8'(p));
      checks++; if (a_pred_index !== 4'(p)) begin errors++; $display("[TB] FAIL mid_scan_index[%0d]: got %0h expected %0h", p, a_pred_index, p); end
      checks++; if (a_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL mid_scan_taken[%0d]: got %0b expected 1", p, a_pred_taken); end
    end
    checks++; if (a_miss_count !== 16'h0) begin errors++; $display("[TB] FAIL mid_miss_after: got %0h expected 0", a_miss_count); end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    a_req_valid = 1'b0; a_req_pc = '0; a_upd_valid = 1'b0; a_upd_index = '0; a_upd_taken = 1'b0;
    b_req_valid = 1'b0; b_req_pc = '0; b_upd_valid = 1'b0; b_upd_index = '0; b_upd_taken = 1'b0;
    #2;
    $display("[TB] starting branch_predictor_table bench");
    test_reset();
    test_saturation();
    test_collision();
    test_history();
    test_back_to_back();
    test_miss();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
